// File: rtl/score_pkg.sv
// score_pkg: shared types, widths and the double-dabble digit adjust for the score path
package score_pkg;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 12;
    localparam int SCORE_W    = 8;
    localparam int DD_ITERS   = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction
endpackage

// File: rtl/score_bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle double-dabble converter; bcd only changes on commit
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);
    localparam logic [2:0] LAST = 3'(DD_ITERS - 1);

    state_t                     state, state_n;
    logic [BCD_W+SCORE_W-1:0]   sr, sr_n;
    logic [2:0]                 cnt, cnt_n;
    logic [BCD_W-1:0]           bcd_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            bcd   <= bcd_n;
        end
    end

    // start preempts any state, so a restart abandons the conversion in flight
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        bcd_n   = bcd;
        if (start) begin
            state_n = SHIFT;
            sr_n    = {{BCD_W{1'b0}}, bin};
            cnt_n   = '0;
        end else if (state == SHIFT) begin
            sr_n    = {dd_adjust(sr[BCD_W+SCORE_W-1:SCORE_W]), sr[SCORE_W-1:0]} << 1;
            cnt_n   = cnt + 3'd1;
            state_n = (cnt == LAST) ? COMMIT : SHIFT;
        end else if (state == COMMIT) begin
            bcd_n   = sr[BCD_W+SCORE_W-1:SCORE_W];
            state_n = IDLE;
        end
    end

    assign busy = state != IDLE;
    assign done = state == COMMIT;
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: frame-paced score counter with high score and BCD conversion in vblank
module score_ctrl
    import score_pkg::*;
#(
    parameter int MOVE_FRAMES = 4,
    parameter int SCORE_MAX   = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic               i_move,
    input  logic               i_game_over,
    input  logic               i_restart,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic [BCD_W-1:0]   o_bcd,
    output logic               o_busy
);
    localparam int                 CW   = $clog2(MOVE_FRAMES + 1);
    localparam logic [CW-1:0]      LAST = CW'(MOVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

    logic [CW-1:0]      cnt, cnt_n;
    logic [SCORE_W-1:0] score_n;
    logic               frame_go, start, done;

    assign frame_go = i_frame_start & ~o_busy;
    assign start    = i_restart | frame_go;

    always_comb begin
        cnt_n   = cnt;
        score_n = o_score;
        if (i_restart) begin
            cnt_n   = '0;
            score_n = '0;
        end else if (frame_go && !i_game_over) begin
            if (!i_move) cnt_n = '0;
            else if (cnt == LAST) begin
                cnt_n   = '0;
                score_n = (o_score >= SMAX) ? SMAX : o_score + SCORE_W'(1);
            end else cnt_n = cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            o_score      <= '0;
            o_high_score <= '0;
        end else begin
            cnt     <= cnt_n;
            o_score <= score_n;
            if (done && !i_restart && o_score > o_high_score) o_high_score <= o_score;
        end
    end

    // the converter loads the post-update score so conversion starts on the same edge
    bin2bcd_seq u_dd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (start),
        .bin     (score_n),
        .busy    (o_busy),
        .done    (done),
        .bcd     (o_bcd)
    );
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed scenario tests for score_ctrl with hand-computed expectations
module tb_score_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        frame_start = 0, move = 0, game_over = 0, restart = 0;
    logic [7:0]  score, high;
    logic [11:0] bcd;
    logic        busy;
    int          total = 0, bad = 0;

    score_ctrl #(.MOVE_FRAMES(4), .SCORE_MAX(255)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_move        (move),
        .i_game_over   (game_over),
        .i_restart     (restart),
        .o_score       (score),
        .o_high_score  (high),
        .o_bcd         (bcd),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic m, input logic g);
        @(negedge clk); move = m; game_over = g; frame_start = 1;
        @(posedge clk); #1; frame_start = 0;
    endtask

    task automatic settle();
        repeat (9) tick();
    endtask

    task automatic run(input int n, input logic m);
        repeat (n) begin frame(m, 0); settle(); end
    endtask

    task automatic restart_game();
        @(negedge clk); restart = 1;
        @(posedge clk); #1; restart = 0;
        settle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick(); total++;
            if (score !== 8'd0 || high !== 8'd0 || bcd !== 12'h000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset c%0d: score=%0d high=%0d bcd=%h busy=%b want 0 0 000 0", i, score, high, bcd, busy);
            end
        end
    endtask

    task automatic test_count();
        run(3, 1);
        total++;
        if (score !== 8'd0) begin bad++; $display("FAIL count_pre: score=%0d want 0", score); end
        frame(1, 0);
        total++;
        if (score !== 8'd1 || busy !== 1'b1 || bcd !== 12'h000) begin
            bad++; $display("FAIL count_edge0: score=%0d busy=%b bcd=%h want 1 1 000", score, busy, bcd);
        end
        for (int e = 1; e <= 8; e++) begin
            tick(); total++;
            if (busy !== 1'b1 || bcd !== 12'h000) begin
                bad++; $display("FAIL count_edge%0d: busy=%b bcd=%h want 1 000", e, busy, bcd);
            end
        end
        tick(); total++;
        if (bcd !== 12'h001 || busy !== 1'b0 || high !== 8'd1) begin
            bad++; $display("FAIL count_edge9: bcd=%h busy=%b high=%0d want 001 0 1", bcd, busy, high);
        end
    endtask

    task automatic test_continuity();
        restart_game();
        run(3, 1); run(1, 0); run(3, 1);
        total++;
        if (score !== 8'd0) begin bad++; $display("FAIL cont_7: score=%0d want 0", score); end
        run(1, 1);
        total++;
        if (score !== 8'd1) begin bad++; $display("FAIL cont_8: score=%0d want 1", score); end
    endtask

    task automatic test_game_over();
        restart_game();
        run(148, 1);
        total++;
        if (score !== 8'd37 || bcd !== 12'h037 || high !== 8'd37) begin
            bad++; $display("FAIL go_37: score=%0d bcd=%h high=%0d want 37 037 37", score, bcd, high);
        end
        repeat (10) begin frame(1, 1); settle(); end
        total++;
        if (score !== 8'd37 || bcd !== 12'h037) begin
            bad++; $display("FAIL go_frozen: score=%0d bcd=%h want 37 037", score, bcd);
        end
        game_over = 0;
        @(negedge clk); restart = 1;
        @(posedge clk); #1; restart = 0;
        total++;
        if (score !== 8'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL go_restart0: score=%0d busy=%b want 0 1", score, busy);
        end
        repeat (8) tick();
        total++;
        if (bcd !== 12'h037) begin bad++; $display("FAIL go_restart8: bcd=%h want 037", bcd); end
        tick(); total++;
        if (bcd !== 12'h000 || busy !== 1'b0 || high !== 8'd37) begin
            bad++; $display("FAIL go_restart9: bcd=%h busy=%b high=%0d want 000 0 37", bcd, busy, high);
        end
    endtask

    task automatic test_restart_abort();
        restart_game();
        run(395, 1);
        total++;
        if (score !== 8'd98 || bcd !== 12'h098 || high !== 8'd98) begin
            bad++; $display("FAIL abort_98: score=%0d bcd=%h high=%0d want 98 098 98", score, bcd, high);
        end
        frame(1, 0);
        total++;
        if (score !== 8'd99) begin bad++; $display("FAIL abort_99: score=%0d want 99", score); end
        repeat (3) tick();
        @(negedge clk); restart = 1;
        @(posedge clk); #1; restart = 0;
        total++;
        if (score !== 8'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_edge4: score=%0d busy=%b want 0 1", score, busy);
        end
        for (int e = 5; e <= 12; e++) begin
            tick(); total++;
            if (bcd !== 12'h098) begin bad++; $display("FAIL abort_edge%0d: bcd=%h want 098", e, bcd); end
        end
        tick(); total++;
        if (bcd !== 12'h000 || busy !== 1'b0 || high !== 8'd98) begin
            bad++; $display("FAIL abort_edge13: bcd=%h busy=%b high=%0d want 000 0 98", bcd, busy, high);
        end
        run(3, 1);
        @(negedge clk); move = 1; restart = 1; frame_start = 1;
        @(posedge clk); #1; restart = 0; frame_start = 0;
        total++;
        if (score !== 8'd0) begin bad++; $display("FAIL coinc_edge0: score=%0d want 0", score); end
        repeat (9) tick();
        total++;
        if (bcd !== 12'h000 || busy !== 1'b0) begin
            bad++; $display("FAIL coinc_edge9: bcd=%h busy=%b want 000 0", bcd, busy);
        end
        run(3, 1);
        total++;
        if (score !== 8'd0) begin bad++; $display("FAIL coinc_3: score=%0d want 0", score); end
        run(1, 1);
        total++;
        if (score !== 8'd1) begin bad++; $display("FAIL coinc_4: score=%0d want 1", score); end
    endtask

    task automatic test_back_to_back();
        restart_game();
        run(3, 1);
        frame(1, 0);
        total++;
        if (score !== 8'd1) begin bad++; $display("FAIL b2b_edge0: score=%0d want 1", score); end
        repeat (2) tick();
        @(negedge clk); move = 1; frame_start = 1;
        @(posedge clk); #1; frame_start = 0;
        total++;
        if (score !== 8'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_ignored: score=%0d busy=%b want 1 1", score, busy);
        end
        repeat (6) tick();
        total++;
        if (bcd !== 12'h001 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_commit: bcd=%h busy=%b want 001 0", bcd, busy);
        end
        run(3, 1);
        total++;
        if (score !== 8'd1) begin bad++; $display("FAIL b2b_3: score=%0d want 1", score); end
        run(1, 1);
        total++;
        if (score !== 8'd2 || bcd !== 12'h002) begin
            bad++; $display("FAIL b2b_4: score=%0d bcd=%h want 2 002", score, bcd);
        end
    endtask

    task automatic test_saturate();
        restart_game();
        run(1016, 1);
        total++;
        if (score !== 8'd254 || bcd !== 12'h254 || high !== 8'd254) begin
            bad++; $display("FAIL sat_254: score=%0d bcd=%h high=%0d want 254 254 254", score, bcd, high);
        end
        run(4, 1);
        total++;
        if (score !== 8'd255) begin bad++; $display("FAIL sat_255: score=%0d want 255", score); end
        run(4, 1);
        total++;
        if (score !== 8'd255 || bcd !== 12'h255 || high !== 8'd255) begin
            bad++; $display("FAIL sat_hold: score=%0d bcd=%h high=%0d want 255 255 255", score, bcd, high);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_continuity();
        test_game_over();
        test_restart_abort();
        test_back_to_back();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
